// File: rtl/sc_shifter_sequencer.sv
// One-hot position shifter with a post-move cooldown window.
// States: OFF (no position), IDLE (accepting moves), HOLD (cooldown counting down).
module sc_shifter_sequencer #(
  parameter int SHIFTER_DATAWIDTH  = 4,
  parameter int SHIFTER_HOLDCYCLES = 8,
  parameter int SHIFTER_INITPOS    = 1
) (
  input  logic                         SC_SHIFTER_SEQUENCER_CLOCK_50,
  input  logic                         SC_SHIFTER_SEQUENCER_RESET_InLow,
  input  logic                         SC_SHIFTER_SEQUENCER_start_In,
  input  logic                         SC_SHIFTER_SEQUENCER_left_In,
  input  logic                         SC_SHIFTER_SEQUENCER_right_In,
  output logic [SHIFTER_DATAWIDTH-1:0] SC_SHIFTER_SEQUENCER_data_OutBUS,
  output logic                         SC_SHIFTER_SEQUENCER_dir_Out,
  output logic                         SC_SHIFTER_SEQUENCER_shift_Out,
  output logic                         SC_SHIFTER_SEQUENCER_blocked_Out,
  output logic                         SC_SHIFTER_SEQUENCER_busy_Out
);

  localparam int W = SHIFTER_DATAWIDTH;
  localparam logic [W-1:0] INIT_VEC  = {{(W-1){1'b0}}, 1'b1} << SHIFTER_INITPOS;
  localparam logic [7:0]   HOLD_LOAD = 8'(SHIFTER_HOLDCYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic           dir_q, dir_d;
  logic           shift_q, shift_d;
  logic           blocked_q, blocked_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           req_left, req_right;

  // Only an unambiguous single-direction request counts as a move.
  assign req_left  = SC_SHIFTER_SEQUENCER_left_In  & ~SC_SHIFTER_SEQUENCER_right_In;
  assign req_right = SC_SHIFTER_SEQUENCER_right_In & ~SC_SHIFTER_SEQUENCER_left_In;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    shift_d   = 1'b0;
    blocked_d = 1'b0;
    cnt_d     = cnt_q;

    if (SC_SHIFTER_SEQUENCER_start_In) begin
      state_d = ST_IDLE;
      data_d  = INIT_VEC;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          data_d = '0;
        end
        ST_IDLE: begin
          if (req_left) begin
            if (data_q[W-1]) begin
              blocked_d = 1'b1;
            end else begin
              data_d  = data_q << 1;
              dir_d   = 1'b1;
              shift_d = 1'b1;
              cnt_d   = HOLD_LOAD;
              state_d = ST_HOLD;
            end
          end else if (req_right) begin
            if (data_q[0]) begin
              blocked_d = 1'b1;
            end else begin
              data_d  = data_q >> 1;
              dir_d   = 1'b0;
              shift_d = 1'b1;
              cnt_d   = HOLD_LOAD;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Leave on the edge that sees zero, so a move at edge k frees edge k+HOLDCYCLES+1.
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_OFF;
          data_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SC_SHIFTER_SEQUENCER_CLOCK_50) begin
    if (!SC_SHIFTER_SEQUENCER_RESET_InLow) begin
      state_q   <= ST_OFF;
      data_q    <= '0;
      dir_q     <= 1'b0;
      shift_q   <= 1'b0;
      blocked_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      shift_q   <= shift_d;
      blocked_q <= blocked_d;
      cnt_q     <= cnt_d;
    end
  end

  assign SC_SHIFTER_SEQUENCER_data_OutBUS  = data_q;
  assign SC_SHIFTER_SEQUENCER_dir_Out      = dir_q;
  assign SC_SHIFTER_SEQUENCER_shift_Out    = shift_q;
  assign SC_SHIFTER_SEQUENCER_blocked_Out  = blocked_q;
  assign SC_SHIFTER_SEQUENCER_busy_Out     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_sc_shifter_sequencer.sv
// Bench for sc_shifter_sequencer: directed sequences with literal expectations,
// then random stimulus, all compared every cycle against a position/deadline model.
module tb_sc_shifter_sequencer;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int INIT = 1;

  logic         clk = 1'b0;
  logic         rstn, start, left, right;
  logic [W-1:0] data;
  logic         dir, shift, blocked, busy;

  int errors = 0;
  int checks = 0;

  // Model: position index (-1 = off), direction, pulses, and the first edge a move may be taken.
  int     m_pos;
  logic   m_dir, m_shift, m_blk, m_busy;
  longint e;
  longint ready_at;

  sc_shifter_sequencer #(
    .SHIFTER_DATAWIDTH (W),
    .SHIFTER_HOLDCYCLES(H),
    .SHIFTER_INITPOS   (INIT)
  ) dut (
    .SC_SHIFTER_SEQUENCER_CLOCK_50   (clk),
    .SC_SHIFTER_SEQUENCER_RESET_InLow(rstn),
    .SC_SHIFTER_SEQUENCER_start_In   (start),
    .SC_SHIFTER_SEQUENCER_left_In    (left),
    .SC_SHIFTER_SEQUENCER_right_In   (right),
    .SC_SHIFTER_SEQUENCER_data_OutBUS(data),
    .SC_SHIFTER_SEQUENCER_dir_Out    (dir),
    .SC_SHIFTER_SEQUENCER_shift_Out  (shift),
    .SC_SHIFTER_SEQUENCER_blocked_Out(blocked),
    .SC_SHIFTER_SEQUENCER_busy_Out   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare at the falling edge.
  task automatic tick();
    logic [W-1:0] exp_data;
    @(posedge clk);
    m_shift = 1'b0;
    m_blk   = 1'b0;
    if (!rstn) begin
      m_pos    = -1;
      m_dir    = 1'b0;
      ready_at = 0;
    end else if (start) begin
      m_pos    = INIT;
      ready_at = 0;
    end else if (m_pos >= 0 && e >= ready_at && left != right) begin
      if (left) begin
        if (m_pos == W - 1) m_blk = 1'b1;
        else begin
          m_pos++; m_dir = 1'b1; m_shift = 1'b1; ready_at = e + H + 1;
        end
      end else begin
        if (m_pos == 0) m_blk = 1'b1;
        else begin
          m_pos--; m_dir = 1'b0; m_shift = 1'b1; ready_at = e + H + 1;
        end
      end
    end
    m_busy = (m_pos >= 0) && (e + 1 < ready_at);
    e++;
    @(negedge clk);
    exp_data = (m_pos < 0) ? '0 : W'(1 << m_pos);
    chk("data",    32'(data),    32'(exp_data));
    chk("dir",     32'(dir),     32'(m_dir));
    chk("shift",   32'(shift),   32'(m_shift));
    chk("blocked", 32'(blocked), 32'(m_blk));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("excl",    32'(shift & blocked), 32'd0);
  endtask

  task automatic drive(input logic r, input logic s, input logic l, input logic rt);
    rstn = r; start = s; left = l; right = rt;
  endtask

  initial begin
    m_pos = -1; m_dir = 1'b0; m_shift = 1'b0; m_blk = 1'b0; m_busy = 1'b0;
    e = 0; ready_at = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0);

    // Reset low two cycles (start/left present but overridden), release, then start.
    tick(); chk("rst_data0", 32'(data), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick(); chk("rst_busy", 32'(busy), 32'h0); chk("rst_dir", 32'(dir), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk("off_data", 32'(data), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk("start_data", 32'(data), 32'h2); chk("start_busy", 32'(busy), 32'h0);

    // Left held 10 cycles: shifts at 0 and 4, blocked from 8 onward.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("l_shift", 32'(shift), 32'((i == 0) || (i == 4)));
      chk("l_blk",   32'(blocked), 32'(i >= 8));
      if (i == 0) chk("l_data0", 32'(data), 32'h4);
      if (i == 4) chk("l_data4", 32'(data), 32'h8);
    end
    chk("l_dir", 32'(dir), 32'h1);

    // Right once, held through cooldown, then refused at LSB.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk("restart", 32'(data), 32'h2);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r_data",  32'(data),    32'h1);
      chk("r_shift", 32'(shift),   32'(i == 0));
      chk("r_busy",  32'(busy),    32'(i < 3));
      chk("r_blk",   32'(blocked), 32'(i == 4));
    end
    chk("r_dir", 32'(dir), 32'h0);

    // Both directions together at 0100: nothing happens.
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick(); chk("b_move", 32'(data), 32'h4);
    drive(1'b1, 1'b0, 1'b0, 1'b0); repeat (3) tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1); tick();
    chk("b_data", 32'(data), 32'h4); chk("b_shift", 32'(shift), 32'h0);
    chk("b_blk", 32'(blocked), 32'h0); chk("b_busy", 32'(busy), 32'h0);

    // Start during cooldown, then reset during cooldown.
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick(); chk("h_busy", 32'(busy), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk("h_start_data", 32'(data), 32'h2); chk("h_start_busy", 32'(busy), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick(); chk("h2_data", 32'(data), 32'h4);
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("h_rst_data", 32'(data), 32'h0); chk("h_rst_busy", 32'(busy), 32'h0);
    chk("h_rst_dir", 32'(dir), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); repeat (5) tick();
    chk("off_stays", 32'(data), 32'h0);

    // Random traffic with occasional start and reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 23) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
